uart_tx_stream: RTL and testbench
=================================

Name: uart_tx_stream

Overview:
Parametrised UART transmitter, successor to the fixed-message transmitter. Accepts arbitrary data words over a valid/ready handshake into an internal FIFO and serialises them LSB-first onto `tx`. Data width, parity mode, stop-bit count and FIFO depth are configurable. Bit timing comes from the shared external `baud_tick` strobe (one pulse per bit period), so several instances can share one baud generator.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH+1), width of `fifo_count`.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- baud_tick  input  1  single-cycle strobe per bit period.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  FIFO can accept a word.
- tx  output  1  serial line, idle high; registered.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  CNT_W  words currently buffered.

Behaviour:
Interface:
- One clock `clk`. `rst` is synchronous and active-high.
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0. FIFO pointers cleared, FSM in IDLE.

Handshake and FIFO:
- A word is pushed on any cycle where `in_valid && in_ready`.
- `in_ready` = !full, computed from the current count only. A pop in the same cycle does not raise `in_ready` while full.
- A pushed word is poppable from the next cycle. No bypass from input to FSM.
- Push and pop in the same cycle leave `fifo_count` unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, START, DATA, PAR, STOP. All transitions happen only on cycles with `baud_tick`=1. `tx` is updated in that same cycle and is visible after the clock edge.
- IDLE: `tx`=1. On tick with FIFO non-empty: pop a word into the shift register, drive `tx`=0, go to START.
- START: on tick, drive `tx`=shift[0], shift right, bit_cnt=0, go to DATA.
- DATA: on tick:
  - If bit_cnt < DATA_W-1: drive the next bit, increment bit_cnt.
  - Else if PARITY!=0: drive the parity bit, go to PAR.
  - Else: drive `tx`=1, stop_cnt=0, go to STOP.
- Parity value: even mode uses XOR of the data word; odd mode uses its inverse. It is computed from the word at pop time.
- PAR: on tick, drive `tx`=1, stop_cnt=0, go to STOP.
- STOP: on tick:
  - If stop_cnt < STOP_BITS-1: hold `tx`=1, increment stop_cnt.
  - Else if FIFO non-empty: pop and drive `tx`=0, go to START. Back-to-back frames have no idle gap.
  - Else go to IDLE, `tx` stays 1.

Timing and boundary conditions:
- Frame length = 1 + DATA_W + (PARITY!=0) + STOP_BITS tick periods, measured from the tick that emits the start bit.
- Every bit is held exactly one tick period. `baud_tick` pulses arriving while IDLE with an empty FIFO are ignored.
- A word written while IDLE starts at the first tick after it becomes poppable.
- `busy` = (state!=IDLE) || (count!=0), registered-equivalent. It deasserts in the cycle the FSM returns to IDLE with an empty FIFO.
- Reset mid-frame: on the next edge `tx`=1, the frame is abandoned, and the FIFO is flushed with no partial completion.
- `baud_tick` asserted continuously is legal; each cycle then counts as one bit period.

Decomposition:
- Package `uart_pkg`:
  - `parity_t` enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - `tx_state_t` enum (IDLE, START, DATA, PAR, STOP).
  - Shared constant `UART_IDLE_LEVEL` = 1'b1.
- Sub-module `uart_sync_fifo`, parametrised by width and depth:
  - Outputs: `full`, `empty`, `count`.
  - Reused later by the UART receiver.
- Shift register, parity and FSM stay in `uart_tx_stream`.

Test Plan:
1. DATA_W=8, PARITY=0, STOP_BITS=1; push 0x50, tick every 4 clocks -> `tx` per tick = 0, 0,0,0,0,1,0,1,0, 1 (10 bits). `busy` is high throughout and drops after the stop period.
2. PARITY=1 (even), push 0x50 -> parity bit 0, frame 11 ticks. PARITY=2 (odd), push 0x0A -> data 0,1,0,1,0,0,0,0, then parity 1.
3. STOP_BITS=2; push 0x50, 0x4F back-to-back -> two stop ticks high, then the start bit of 0x4F on the very next tick with no idle gap. Total 22 ticks.
4. FIFO_DEPTH=4, no ticks; push 5 words -> `in_ready` low after 4, `fifo_count`=4, 5th push refused. Enable ticks -> 4 frames sent in order, `fifo_count` decrements at each pop.
5. Assert `rst` during data bit 3 of 0x4C with 2 words queued -> next cycle `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=1. No further transmission without new pushes.
6. DATA_W=5, `baud_tick` tied high; push 0x1F -> `tx` = 0,1,1,1,1,1,1 over 7 consecutive cycles, then idle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter, its FIFO and
// the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with show-ahead read data.
// Ports: clk, rst (sync, active-high), wr_en/wr_data (push, ignored when full),
// rd_en/rd_data (pop, ignored when empty; rd_data is the head entry),
// full, empty, count (entries held).
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: FIFO-buffered UART transmitter, LSB first, timed by an
// external baud_tick strobe (one pulse per bit period).
// Ports: clk, rst (sync, active-high), baud_tick, in_data/in_valid/in_ready
// (push handshake into the FIFO), tx (registered serial line, idle high),
// busy (frame in progress or words buffered), fifo_count (words buffered).
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int                BC_W      = $clog2(DATA_W);
  localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(DATA_W - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam parity_t           PAR_MODE  = parity_t'(2'(PARITY));

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (PAR_MODE == PAR_ODD) ? ~(^w) : ^w;
  endfunction

  tx_state_t         state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_n;
  logic              stop_cnt, stop_cnt_n;
  logic              par_bit, par_n;
  logic              tx_n;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_n      = par_bit;
    tx_n       = tx;
    pop        = 1'b0;
    if (baud_tick) begin
      case (state)
        IDLE: begin
          tx_n = UART_IDLE_LEVEL;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_head;
            par_n   = parity_of(fifo_head);
            tx_n    = 1'b0;
            state_n = START;
          end
        end
        START: begin
          tx_n      = shift[0];
          shift_n   = {1'b0, shift[DATA_W-1:1]};
          bit_cnt_n = '0;
          state_n   = DATA;
        end
        DATA: begin
          if (bit_cnt < BIT_LAST) begin
            tx_n      = shift[0];
            shift_n   = {1'b0, shift[DATA_W-1:1]};
            bit_cnt_n = bit_cnt + BC_W'(1);
          end else if (PAR_MODE != PAR_NONE) begin
            tx_n    = par_bit;
            state_n = PAR;
          end else begin
            tx_n       = UART_IDLE_LEVEL;
            stop_cnt_n = 1'b0;
            state_n    = STOP;
          end
        end
        PAR: begin
          tx_n       = UART_IDLE_LEVEL;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
        STOP: begin
          tx_n = UART_IDLE_LEVEL;
          if (stop_cnt < STOP_LAST) begin
            stop_cnt_n = 1'b1;
          end else if (!fifo_empty) begin
            // Next frame starts on this very tick: no idle gap.
            pop     = 1'b1;
            shift_n = fifo_head;
            par_n   = parity_of(fifo_head);
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          tx_n    = UART_IDLE_LEVEL;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= UART_IDLE_LEVEL;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    shift   <= shift_n;
    par_bit <= par_n;
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: randomized self-checking bench for uart_tx_stream.
// Instance a: 8 data bits, no parity, 1 stop bit. Instance b: 7 data bits,
// odd parity, 2 stop bits. Expected line levels come from a frame model.
module tb_uart_tx_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;

  logic [7:0] in_data_a;
  logic       in_valid_a, in_ready_a, tx_a, busy_a;
  logic [2:0] count_a;

  logic [6:0] in_data_b;
  logic       in_valid_b, in_ready_b, tx_b, busy_b;
  logic [2:0] count_b;

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_stream #(
    .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(count_a)
  );

  uart_tx_stream #(
    .DATA_W(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(count_b)
  );

  // Reference model: the line levels of one frame, one entry per tick period.
  task automatic add_frame(input int w, input int dw, input int par, input int sb);
    int ones;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++) exp_q.push_back(bit'((w >> i) & 1));
    if (par != 0) begin
      ones = $countones(w & ((1 << dw) - 1));
      exp_q.push_back(bit'((par == 1) ? (ones % 2) : 1 - (ones % 2)));
    end
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int gap);
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
    repeat (gap) step();
  endtask

  task automatic push_a(input logic [7:0] w);
    in_data_a  = w;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [6:0] w);
    in_data_b  = w;
    in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; baud_tick = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_data_a = '0; in_data_b = '0;
    step(); step();
    rst = 1'b0;
    n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL reset_tx_a: got %b want 1", tx_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_ready_a: got %b want 1", in_ready_a); end
    n_vec++; if (count_a !== 3'd0) begin n_err++; $display("FAIL reset_count_a: got %0d want 0", count_a); end
    n_vec++; if (tx_b !== 1'b1) begin n_err++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
    n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
  endtask

  task automatic test_single_frame(input logic [7:0] w, input int gap);
    bit e;
    int n;
    exp_q.delete();
    add_frame(w, 8, 0, 1);
    push_a(w);
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL single_busy_queued: got %b want 1", busy_a); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick(gap);
      e = exp_q.pop_front();
      n_vec++; if (tx_a !== e) begin n_err++; $display("FAIL single_tx w=%h bit%0d: got %b want %b", w, i, tx_a, e); end
      n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL single_busy w=%h bit%0d: got %b want 1", w, i, busy_a); end
    end
    tick(gap);
    n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL single_idle_tx: got %b want 1", tx_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_back_to_back_b(input logic [6:0] w0, input logic [6:0] w1);
    bit e;
    int n;
    exp_q.delete();
    add_frame(w0, 7, 2, 2);
    add_frame(w1, 7, 2, 2);
    push_b(w0);
    push_b(w1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 2));
      e = exp_q.pop_front();
      n_vec++; if (tx_b !== e) begin n_err++; $display("FAIL b2b_tx %h,%h bit%0d: got %b want %b", w0, w1, i, tx_b, e); end
    end
    tick(1);
    n_vec++; if (tx_b !== 1'b1) begin n_err++; $display("FAIL b2b_idle_tx: got %b want 1", tx_b); end
    n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy: got %b want 0", busy_b); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] w [5];
    bit e;
    exp_q.delete();
    for (int k = 0; k < 5; k++) w[k] = 8'($urandom);
    for (int k = 0; k < 4; k++) add_frame(w[k], 8, 0, 1);
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (in_ready_a !== (k < 4)) begin n_err++; $display("FAIL full_ready push%0d: got %b want %b", k, in_ready_a, (k < 4)); end
      push_a(w[k]);
    end
    n_vec++; if (count_a !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", count_a); end
    n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL full_ready_after: got %b want 0", in_ready_a); end
    for (int t = 0; t < 40; t++) begin
      tick(1);
      e = exp_q.pop_front();
      n_vec++; if (tx_a !== e) begin n_err++; $display("FAIL full_tx tick%0d: got %b want %b", t, tx_a, e); end
      if (t % 10 == 0) begin
        n_vec++; if (count_a !== 3'(3 - t / 10)) begin n_err++; $display("FAIL full_count_pop tick%0d: got %0d want %0d", t, count_a, 3 - t / 10); end
      end
    end
    tick(1);
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL full_drained_busy: got %b want 0", busy_a); end
    n_vec++; if (count_a !== 3'd0) begin n_err++; $display("FAIL full_drained_count: got %0d want 0", count_a); end
  endtask

  task automatic test_reset_midframe();
    bit e;
    exp_q.delete();
    add_frame(8'h4C, 8, 0, 1);
    push_a(8'h4C); push_a(8'h11); push_a(8'h22);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      e = exp_q.pop_front();
      n_vec++; if (tx_a !== e) begin n_err++; $display("FAIL mid_tx bit%0d: got %b want %b", i, tx_a, e); end
    end
    n_vec++; if (count_a !== 3'd2) begin n_err++; $display("FAIL mid_count_before: got %0d want 2", count_a); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx: got %b want 1", tx_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
    n_vec++; if (count_a !== 3'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", count_a); end
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", in_ready_a); end
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n_vec++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin n_err++; $display("FAIL mid_quiet tick%0d: got tx=%b busy=%b want tx=1 busy=0", i, tx_a, busy_a); end
    end
  endtask

  task automatic test_continuous_tick(input logic [7:0] w);
    bit e;
    exp_q.delete();
    add_frame(w, 8, 0, 1);
    baud_tick = 1'b1;
    push_a(w);
    for (int i = 0; i < 10; i++) begin
      step();
      e = exp_q.pop_front();
      n_vec++; if (tx_a !== e) begin n_err++; $display("FAIL cont_tx w=%h cyc%0d: got %b want %b", w, i, tx_a, e); end
    end
    step();
    n_vec++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin n_err++; $display("FAIL cont_idle: got tx=%b busy=%b want tx=1 busy=0", tx_a, busy_a); end
    step();
    n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL cont_idle2_tx: got %b want 1", tx_a); end
    baud_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame(8'h50, 3);
    for (int i = 0; i < 4; i++) test_single_frame(8'($urandom), $urandom_range(0, 3));
    test_back_to_back_b(7'h50, 7'h4F);
    test_back_to_back_b(7'h0A, 7'($urandom));
    for (int i = 0; i < 2; i++) test_back_to_back_b(7'($urandom), 7'($urandom));
    test_fifo_full();
    test_reset_midframe();
    test_continuous_tick(8'h1F);
    test_continuous_tick(8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
